monitor_verificacion: RTL and testbench

- Consumes the 1-bit registered compare result from the downstream verifier of the pipelined adder bench.
- Each measurement window first discards the pipeline fill cycles. It then samples a programmed number of compare results.
- It counts mismatches and records the index of the first mismatch.
- It reports a latched pass/fail verdict, and is used as the self-checking end stage of every adder testbench.

---
 rtl/monitor_verificacion_pkg.sv | 10 +
 rtl/monitor_verificacion_if.sv | 41 ++++
 rtl/monitor_verificacion_contador_saturado.sv | 27 ++
 rtl/monitor_verificacion.sv | 124 ++++++++++++
 tb/tb_monitor_verificacion.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/monitor_verificacion_pkg.sv
// Shared constants for the adder-bench verdict monitor.
// State encoding is kept as plain 2-bit constants for legacy benches.
package verif_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ESPERA   = 2'd1;
  localparam logic [1:0] ST_MUESTREO = 2'd2;
  localparam logic [1:0] ST_FIN      = 2'd3;

endpackage

// File: rtl/monitor_verificacion_if.sv
// Control/result bundle between an adder bench and its verdict monitor.
// master drives the window, slave is the monitor itself.
interface monitor_verificacion_if #(
  parameter int CNT_BITS = 8
);

  logic                inicio;
  logic [CNT_BITS-1:0] num_muestras;
  logic                verificador;
  logic                ocupado;
  logic                terminado;
  logic                pasa;
  logic [CNT_BITS-1:0] cuenta_errores;
  logic [CNT_BITS-1:0] primer_error;
  logic                error_valido;

  modport master (
    output inicio,
    output num_muestras,
    output verificador,
    input  ocupado,
    input  terminado,
    input  pasa,
    input  cuenta_errores,
    input  primer_error,
    input  error_valido
  );

  modport slave (
    input  inicio,
    input  num_muestras,
    input  verificador,
    output ocupado,
    output terminado,
    output pasa,
    output cuenta_errores,
    output primer_error,
    output error_valido
  );

endinterface

// File: rtl/monitor_verificacion_contador_saturado.sv
// Up-counter with synchronous clear that sticks at all-ones.
// Used for the mismatch tally so long failing windows never wrap.
module contador_saturado #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/monitor_verificacion.sv
// Verdict monitor: skips pipeline fill, samples N compare results,
// tallies mismatches, records the first one and latches pass/fail.
module monitor_verificacion
  import verif_pkg::*;
#(
  parameter int CNT_BITS = 8,
  parameter int LATENCIA = 3
) (
  input  logic                   clk,
  input  logic                   reset_L,
  monitor_verificacion_if.slave  bus
);

  localparam logic [CNT_BITS-1:0] LAT_LAST =
    CNT_BITS'((LATENCIA > 0) ? LATENCIA - 1 : 0);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [CNT_BITS-1:0] r_n;
  logic [CNT_BITS-1:0] r_lat;
  logic [CNT_BITS-1:0] r_idx;
  logic [CNT_BITS-1:0] r_primer;
  logic                r_valido;
  logic                r_term;
  logic                r_pasa;
  logic [CNT_BITS-1:0] w_err;
  logic                w_start;
  logic                w_miss;
  logic                w_lat_done;
  logic                w_smp_done;

  assign w_start = ((r_state == ST_IDLE) || (r_state == ST_FIN))
                 && bus.inicio;

  // Anything but a clean 1 (0, x, z) counts as a mismatch.
  assign w_miss = (r_state == ST_MUESTREO)
                && !(bus.verificador === 1'b1);

  assign w_lat_done = (r_lat == LAT_LAST);
  assign w_smp_done = (r_idx == (r_n - 1'b1));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_FIN: begin
        if (bus.inicio) begin
          if (LATENCIA > 0)
            w_next = ST_ESPERA;
          else if (bus.num_muestras == '0)
            w_next = ST_FIN;
          else
            w_next = ST_MUESTREO;
        end
      end
      ST_ESPERA: begin
        if (w_lat_done)
          w_next = (r_n == '0) ? ST_FIN : ST_MUESTREO;
      end
      ST_MUESTREO: begin
        if (w_smp_done)
          w_next = ST_FIN;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= ST_IDLE;
      r_n      <= '0;
      r_lat    <= '0;
      r_idx    <= '0;
      r_primer <= '0;
      r_valido <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_n      <= bus.num_muestras;
        r_lat    <= '0;
        r_idx    <= '0;
        r_primer <= '0;
        r_valido <= 1'b0;
      end else if (r_state == ST_ESPERA) begin
        r_lat <= r_lat + 1'b1;
      end else if (r_state == ST_MUESTREO) begin
        r_idx <= r_idx + 1'b1;
        if (w_miss && !r_valido) begin
          r_primer <= r_idx;
          r_valido <= 1'b1;
        end
      end
    end
  end

  // Verdict lags entry to FIN by one cycle so pasa sees the final tally.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_term <= 1'b0;
      r_pasa <= 1'b0;
    end else begin
      r_term <= (r_state == ST_FIN) && !w_start;
      r_pasa <= (r_state == ST_FIN) && !w_start && (w_err == '0);
    end
  end

  contador_saturado #(
    .W (CNT_BITS)
  ) u_errores (
    .clk   (clk),
    .rst_n (reset_L),
    .i_clr (w_start),
    .i_inc (w_miss),
    .o_cnt (w_err)
  );

  assign bus.ocupado        = (r_state == ST_ESPERA)
                           || (r_state == ST_MUESTREO);
  assign bus.terminado      = r_term;
  assign bus.pasa           = r_pasa;
  assign bus.cuenta_errores = w_err;
  assign bus.primer_error   = r_primer;
  assign bus.error_valido   = r_valido;

endmodule

// File: tb/tb_monitor_verificacion.sv
// Self-checking bench for monitor_verificacion (three parameter sets).
// Expected verdicts come from a window-level model over sample masks.
module tb_monitor_verificacion;

  logic clk;
  logic reset_L;
  int   vectors;
  int   miscompares;

  monitor_verificacion_if #(.CNT_BITS(8)) ia ();
  monitor_verificacion_if #(.CNT_BITS(4)) ib ();
  monitor_verificacion_if #(.CNT_BITS(8)) ic ();

  monitor_verificacion #(.CNT_BITS(8), .LATENCIA(3)) dut_a (
    .clk(clk), .reset_L(reset_L), .bus(ia)
  );
  monitor_verificacion #(.CNT_BITS(4), .LATENCIA(3)) dut_b (
    .clk(clk), .reset_L(reset_L), .bus(ib)
  );
  monitor_verificacion #(.CNT_BITS(8), .LATENCIA(0)) dut_c (
    .clk(clk), .reset_L(reset_L), .bus(ic)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window on dut_a (L=3). mask[s]=1 means sample s is a mismatch.
  task automatic run_a(input string tag, input int n,
                       input logic [255:0] mask, input bit xmiss,
                       input int pulse_cyc);
    int lat;
    int exp_t;
    int got_t;
    int e_cnt;
    int e_first;
    bit e_val;
    lat = 3;
    exp_t = 1 + lat + n;
    got_t = -1;
    e_cnt = 0;
    e_first = 0;
    e_val = 0;
    for (int s = 0; s < n; s++) begin
      if (mask[s]) begin
        if (!e_val) begin
          e_first = s;
          e_val = 1;
        end
        if (e_cnt < 255) e_cnt++;
      end
    end
    @(negedge clk);
    ia.inicio = 1'b1;
    ia.num_muestras = n[7:0];
    @(negedge clk);
    ia.inicio = 1'b0;
    ia.num_muestras = 8'($urandom);
    vectors++;
    if (ia.cuenta_errores !== 8'd0 || ia.error_valido !== 1'b0 ||
        ia.primer_error !== 8'd0 || ia.terminado !== 1'b0 ||
        ia.ocupado !== 1'b1) begin
      miscompares++;
      $display("FAIL %s start-clear: err=%0d val=%b idx=%0d term=%b ocup=%b want 0 0 0 0 1",
               tag, ia.cuenta_errores, ia.error_valido,
               ia.primer_error, ia.terminado, ia.ocupado);
    end
    for (int cyc = 1; cyc <= exp_t + 3 && got_t < 0; cyc++) begin
      int s;
      s = cyc - lat - 1;
      if (s >= 0 && s < n)
        ia.verificador = mask[s] ? (xmiss ? 1'bx : 1'b0) : 1'b1;
      else
        ia.verificador = 1'bx;
      ia.inicio = (cyc == pulse_cyc);
      if (cyc == pulse_cyc) ia.num_muestras = 8'($urandom);
      @(negedge clk);
      if (ia.terminado === 1'b1) got_t = cyc;
    end
    ia.inicio = 1'b0;
    ia.verificador = 1'b1;
    vectors++;
    if (got_t != exp_t) begin
      miscompares++;
      $display("FAIL %s terminado cycle: got %0d want %0d",
               tag, got_t, exp_t);
    end
    vectors++;
    if (ia.cuenta_errores !== 8'(e_cnt)) begin
      miscompares++;
      $display("FAIL %s cuenta_errores: got %0d want %0d",
               tag, ia.cuenta_errores, e_cnt);
    end
    vectors++;
    if (ia.error_valido !== e_val ||
        ia.primer_error !== 8'(e_val ? e_first : 0)) begin
      miscompares++;
      $display("FAIL %s primer_error: got %0d/%b want %0d/%b",
               tag, ia.primer_error, ia.error_valido, e_first, e_val);
    end
    vectors++;
    if (ia.pasa !== (e_cnt == 0) || ia.ocupado !== 1'b0) begin
      miscompares++;
      $display("FAIL %s pasa/ocupado: got %b/%b want %b/0",
               tag, ia.pasa, ia.ocupado, (e_cnt == 0));
    end
  endtask

  task automatic test_reset();
    logic [255:0] m;
    reset_L = 1'b0;
    @(negedge clk);
    vectors++;
    if (ia.ocupado !== 1'b0 || ia.terminado !== 1'b0 ||
        ia.pasa !== 1'b0 || ia.cuenta_errores !== 8'd0 ||
        ia.primer_error !== 8'd0 || ia.error_valido !== 1'b0) begin
      miscompares++;
      $display("FAIL reset state: ocup=%b term=%b pasa=%b err=%0d want all 0",
               ia.ocupado, ia.terminado, ia.pasa, ia.cuenta_errores);
    end
    reset_L = 1'b1;
    @(negedge clk);
    ia.inicio = 1'b1;
    ia.num_muestras = 8'd10;
    @(negedge clk);
    ia.inicio = 1'b0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      int s;
      s = cyc - 4;
      ia.verificador = (s >= 0) ? 1'b0 : 1'bx;
      @(negedge clk);
    end
    ia.verificador = 1'b1;
    vectors++;
    if (ia.cuenta_errores !== 8'd4 || ia.ocupado !== 1'b1) begin
      miscompares++;
      $display("FAIL reset pre-abort: err=%0d ocup=%b want 4/1",
               ia.cuenta_errores, ia.ocupado);
    end
    #2 reset_L = 1'b0;
    #1;
    vectors++;
    if (ia.ocupado !== 1'b0 || ia.terminado !== 1'b0 ||
        ia.pasa !== 1'b0 || ia.cuenta_errores !== 8'd0 ||
        ia.primer_error !== 8'd0 || ia.error_valido !== 1'b0) begin
      miscompares++;
      $display("FAIL reset abort: ocup=%b err=%0d val=%b want all 0",
               ia.ocupado, ia.cuenta_errores, ia.error_valido);
    end
    @(negedge clk);
    reset_L = 1'b1;
    m = '0;
    m[1] = 1'b1;
    run_a("reset_rerun", 10, m, 1'b0, -1);
  endtask

  task automatic test_all_pass();
    logic [255:0] m;
    m = '0;
    run_a("all_pass", 10, m, 1'b0, -1);
  endtask

  task automatic test_mismatches();
    logic [255:0] m;
    m = '0;
    m[2] = 1'b1;
    m[5] = 1'b1;
    m[7] = 1'b1;
    run_a("mismatch", 10, m, 1'b0, -1);
  endtask

  task automatic test_inicio_mid();
    logic [255:0] m;
    m = '0;
    m[6] = 1'b1;
    run_a("inicio_mid_espera", 12, m, 1'b0, 2);
    run_a("inicio_mid_muestreo", 12, m, 1'b1, 9);
  endtask

  task automatic test_inicio_en_fin();
    logic [255:0] m;
    m = '0;
    m[0] = 1'b1;
    m[3] = 1'b1;
    run_a("fin_first", 5, m, 1'b0, -1);
    m = '0;
    run_a("fin_restart", 7, m, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [255:0] m;
    int n;
    for (int k = 0; k < 8; k++) begin
      n = (k == 7) ? 255 : int'($urandom_range(0, 40));
      m = '0;
      for (int s = 0; s < n; s++)
        m[s] = ($urandom_range(0, 3) == 0);
      if (k == 2) m = '0;
      run_a($sformatf("random%0d_n%0d", k, n), n, m,
            1'($urandom_range(0, 1)), -1);
    end
  endtask

  task automatic test_saturacion();
    int exp_t;
    int got_t;
    int e_cnt;
    exp_t = 1 + 3 + 15;
    got_t = -1;
    e_cnt = 0;
    for (int s = 0; s < 15; s++)
      if (e_cnt < 15) e_cnt++;
    @(negedge clk);
    ib.inicio = 1'b1;
    ib.num_muestras = 4'd15;
    @(negedge clk);
    ib.inicio = 1'b0;
    for (int cyc = 1; cyc <= exp_t + 3 && got_t < 0; cyc++) begin
      ib.verificador = 1'bx;
      @(negedge clk);
      if (ib.terminado === 1'b1) got_t = cyc;
    end
    ib.verificador = 1'b1;
    vectors++;
    if (got_t != exp_t) begin
      miscompares++;
      $display("FAIL sat terminado cycle: got %0d want %0d", got_t, exp_t);
    end
    vectors++;
    if (ib.cuenta_errores !== 4'(e_cnt) || ib.primer_error !== 4'd0 ||
        ib.error_valido !== 1'b1 || ib.pasa !== 1'b0) begin
      miscompares++;
      $display("FAIL sat verdict: err=%0d idx=%0d val=%b pasa=%b want %0d 0 1 0",
               ib.cuenta_errores, ib.primer_error, ib.error_valido,
               ib.pasa, e_cnt);
    end
  endtask

  task automatic run_c(input string tag, input int n, input int bad);
    int exp_t;
    int got_t;
    exp_t = 1 + n;
    got_t = -1;
    @(negedge clk);
    ic.inicio = 1'b1;
    ic.num_muestras = n[7:0];
    @(negedge clk);
    ic.inicio = 1'b0;
    if (got_t < 0 && ic.terminado === 1'b1) got_t = 0;
    for (int cyc = 1; cyc <= exp_t + 3 && got_t < 0; cyc++) begin
      ic.verificador = ((cyc - 1) == bad) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (ic.terminado === 1'b1) got_t = cyc;
    end
    ic.verificador = 1'b1;
    vectors++;
    if (got_t != exp_t) begin
      miscompares++;
      $display("FAIL %s terminado cycle: got %0d want %0d",
               tag, got_t, exp_t);
    end
    vectors++;
    if (ic.pasa !== (bad < 0) ||
        ic.cuenta_errores !== 8'((bad < 0) ? 0 : 1) ||
        ic.primer_error !== 8'((bad < 0) ? 0 : bad)) begin
      miscompares++;
      $display("FAIL %s verdict: pasa=%b err=%0d idx=%0d bad=%0d",
               tag, ic.pasa, ic.cuenta_errores, ic.primer_error, bad);
    end
  endtask

  task automatic test_boundary_lat0();
    run_c("lat0_n0", 0, -1);
    run_c("lat0_n5", 5, 4);
    run_c("lat0_n0_again", 0, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_L = 1'b0;
    ia.inicio = 1'b0;
    ia.num_muestras = '0;
    ia.verificador = 1'b1;
    ib.inicio = 1'b0;
    ib.num_muestras = '0;
    ib.verificador = 1'b1;
    ic.inicio = 1'b0;
    ic.num_muestras = '0;
    ic.verificador = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_all_pass();
    test_mismatches();
    test_inicio_mid();
    test_inicio_en_fin();
    test_random();
    test_saturacion();
    test_boundary_lat0();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
